instr_select_mc: RTL and testbench
==================================

# instr_select_mc

Multi-channel instruction selector: it captures instructions from NUM_SRC independent sources, such as the board switches, instruction memory or a debug port. Each source has its own single-entry holding register, so simultaneous loads are buffered rather than lost. A priority arbiter forwards one pending instruction at a time into a registered output stage, which uses a valid/ready handshake with the execute stage. The block sits between the instruction sources and the decoder/datapath, and `halt` freezes issue.

## Interface
- WIDTH, 16: instruction width in bits.
- NUM_SRC, 2: number of instruction sources, 2..8. Channel 0 has the highest fixed priority.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- src_strobe  in  NUM_SRC  per-channel single-cycle load request.
- src_instr  in  NUM_SRC*WIDTH  per-channel instruction; channel i occupies bits [i*WIDTH +: WIDTH].
- halt  in  1  when high, blocks issue to the output stage. Capture into holding registers continues.
- exec_ready  in  1  execute stage accepts `instr_out` this cycle.
- overrun_clr  in  1  clears all `overrun` bits.
- instr_out  out  WIDTH  registered instruction to execute; holds its value until the next issue.
- instr_valid  out  1  `instr_out` holds an unconsumed instruction.
- instr_src  out  max(1,$clog2(NUM_SRC))  channel that produced `instr_out`.
- overrun  out  NUM_SRC  sticky flag: a strobe was dropped because the holding register was occupied.

## Operation
- Holding register per channel: `pend[i]` plus `hold[i]` (WIDTH bits).
  - A strobe with `pend[i]` = 0 captures `src_instr` and sets `pend[i]`.
  - A strobe with `pend[i]` = 1 that is not being granted this cycle drops the data, leaves `hold[i]` unchanged and sets `overrun[i]`.
  - A strobe on a channel being granted in the same cycle captures the new data, `pend[i]` stays 1, and no overrun is raised.
- Issue condition: `!halt && |pend && (!instr_valid || exec_ready)`.
  - On issue, the winner's `hold` is loaded into `instr_out`, the winner's index into `instr_src`, `instr_valid` is set and the winner's `pend` is cleared.
- Consume without issue: `instr_valid && exec_ready` with no new issue clears `instr_valid`. `instr_out` and `instr_src` keep their values.
- Fixed priority (default): the lowest pending index wins.
- While `halt` is high:
  - `instr_out`, `instr_src` and `instr_valid` are frozen.
  - `exec_ready` is ignored: the output is not consumed.
  - Holding registers still capture strobes, and overrun rules still apply.
- `overrun_clr`: clears all bits. A set event on the same cycle wins for that bit.
- Reset:
  - `instr_out` = 0, `instr_src` = 0, `instr_valid` = 0, `overrun` = 0.
  - All `pend` = 0; `hold` contents are don't-care.
  - Round-robin pointer = NUM_SRC-1.
  - Reset asserted mid-operation discards all pending and output state on that edge.

## Timing
- Strobe sampled at edge E → `pend` set after E → earliest `instr_valid` after edge E+1. Minimum latency is 2 cycles.
- Back-to-back throughput is 1 instruction/cycle while `exec_ready` is held high.
- `instr_out` changes only on an issue edge; it never glitches between issues.
- Release of `halt`: issue may occur on the first edge where `halt` is low.
- No combinational path from inputs to outputs.

## Configuration
- INSTR_SEL_RR_EN defined: round-robin arbitration.
  - A pointer holds the last granted index.
  - The winner is the first pending channel searching upward, with wrap-around, from pointer+1.
  - The pointer updates on every issue.
  - After reset, channel 0 is searched first.
- INSTR_SEL_RR_EN undefined: fixed priority as in Operation. There is no pointer register.

## Structure
- Package `instr_sel_pkg`:
  - default WIDTH and NUM_SRC constants;
  - a `src_idx_t` typedef for channel indices;
  - a function computing the index width.
- Sub-module `instr_sel_arb`, purely combinational:
  - inputs: `pend` vector and pointer;
  - outputs: one-hot grant and encoded index;
  - contains the INSTR_SEL_RR_EN switch.
- Top level contains the holding registers, output stage, overrun logic and pointer.

## Test plan
- Reset, then strobe ch1 with 16'hA5A5 at cycle 0, `exec_ready` = 1 → `instr_valid` = 1, `instr_out` = A5A5 and `instr_src` = 1 after the cycle 1 edge; `instr_valid` drops one cycle later.
- Strobe ch0 = 16'h1111 and ch1 = 16'h2222 in the same cycle, fixed priority → 1111 (src 0) issues, then 2222 (src 1) issues on the next cycle; `overrun` stays 0.
- Strobe ch1 twice, 3 and 7, while `halt` = 1 → `overrun[1]` = 1, `hold` keeps 3; after `halt` drops, 3 issues. Then pulse `overrun_clr` → `overrun` = 0.
- `exec_ready` = 0 with `instr_out` valid, strobe ch0 = 16'hBEEF → `instr_out` unchanged until `exec_ready` = 1, then BEEF issues on that edge.
- With INSTR_SEL_RR_EN, NUM_SRC = 3 and all channels held pending by re-strobing on each grant → grant order 0,1,2,0,1,2.
- Assert reset while ch0 and ch2 are pending and `instr_valid` = 1 → all outputs return to 0 the next cycle and no issue occurs afterwards without a new strobe.

Source files
------------

// File: rtl/instr_sel_pkg.sv
// Shared constants, channel index type and index-width helper for the instruction selector.
package instr_sel_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultNumSrc = 2;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(DefaultNumSrc)-1:0] src_idx_t;

endpackage

// File: rtl/instr_select_mc_if.sv
// Source/control/output bundle of instr_select_mc; slave is the selector side.
interface instr_select_mc_if #(
  parameter int unsigned WIDTH   = instr_sel_pkg::DefaultWidth,
  parameter int unsigned NUM_SRC = instr_sel_pkg::DefaultNumSrc
) ();

  logic [NUM_SRC-1:0]                             src_strobe;
  logic [NUM_SRC*WIDTH-1:0]                       src_instr;
  logic                                           halt;
  logic                                           exec_ready;
  logic                                           overrun_clr;
  logic [WIDTH-1:0]                               instr_out;
  logic                                           instr_valid;
  logic [instr_sel_pkg::idx_width(NUM_SRC)-1:0]   instr_src;
  logic [NUM_SRC-1:0]                             overrun;

  modport master (
    output src_strobe, src_instr, halt, exec_ready, overrun_clr,
    input  instr_out, instr_valid, instr_src, overrun
  );

  modport slave (
    input  src_strobe, src_instr, halt, exec_ready, overrun_clr,
    output instr_out, instr_valid, instr_src, overrun
  );

endinterface

// File: rtl/instr_sel_arb.sv
// Combinational arbiter: fixed lowest-index priority, or round-robin from ptr+1 when
// INSTR_SEL_RR_EN is defined.
module instr_sel_arb import instr_sel_pkg::*; #(
  parameter int unsigned NUM_SRC = DefaultNumSrc,
  parameter int unsigned IdxW    = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] pend,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx
);

`ifdef INSTR_SEL_RR_EN
  logic [IdxW-1:0] cand;

  // Walk from farthest to nearest so the channel right after ptr overrides the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = NUM_SRC; k >= 1; k--) begin
      cand = IdxW'((32'(ptr) + k) % NUM_SRC);
      if (pend[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/instr_select_mc.sv
// Multi-source instruction selector with per-channel holding registers and a registered
// valid/ready output stage. INSTR_SEL_RR_EN selects round-robin arbitration.
module instr_select_mc import instr_sel_pkg::*; #(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned NUM_SRC = DefaultNumSrc
) (
  input logic              clk,
  input logic              reset,
  instr_select_mc_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NUM_SRC);

  logic [NUM_SRC-1:0] pend_q, pend_d, capture, gnt, issue_gnt, ovr_set;
  logic [NUM_SRC-1:0] overrun_q, overrun_d;
  logic [WIDTH-1:0]   hold_q [NUM_SRC];
  logic [IdxW-1:0]    ptr, gnt_idx;
  logic               issue;

  logic [WIDTH-1:0]   out_q, out_d;
  logic [IdxW-1:0]    src_q, src_d;
  logic               valid_q, valid_d;

  instr_sel_arb #(
    .NUM_SRC (NUM_SRC),
    .IdxW    (IdxW)
  ) u_arb (
    .pend    (pend_q),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign issue     = !bus.halt && (|pend_q) && (!valid_q || bus.exec_ready);
  assign issue_gnt = issue ? gnt : '0;

  // A strobe on the channel being granted refills it; otherwise an occupied slot drops data.
  assign capture   = bus.src_strobe & (~pend_q | issue_gnt);
  assign pend_d    = capture | (pend_q & ~issue_gnt);
  assign ovr_set   = bus.src_strobe & pend_q & ~issue_gnt;
  assign overrun_d = (overrun_q & ~{NUM_SRC{bus.overrun_clr}}) | ovr_set;

  always_comb begin
    out_d   = out_q;
    src_d   = src_q;
    valid_d = valid_q;
    if (issue) begin
      out_d   = hold_q[gnt_idx];
      src_d   = gnt_idx;
      valid_d = 1'b1;
    end else if (!bus.halt && valid_q && bus.exec_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      overrun_q <= '0;
      out_q     <= '0;
      src_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      out_q     <= out_d;
      src_q     <= src_d;
      valid_q   <= valid_d;
    end
  end

  // Holding data needs no reset; pend qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (capture[i]) begin
        hold_q[i] <= bus.src_instr[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef INSTR_SEL_RR_EN
  logic [IdxW-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IdxW'(NUM_SRC - 1);
    end else if (issue) begin
      ptr_q <= gnt_idx;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = IdxW'(NUM_SRC - 1);
`endif

  assign bus.instr_out   = out_q;
  assign bus.instr_src   = src_q;
  assign bus.instr_valid = valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_instr_select_mc.sv
// Directed vector bench for instr_select_mc (WIDTH=16, NUM_SRC=2).
module tb_instr_select_mc;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = 2;

  logic clk;
  logic reset;

  instr_select_mc_if #(.WIDTH(W), .NUM_SRC(NS)) bus ();

  instr_select_mc #(.WIDTH(W), .NUM_SRC(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp packs {instr_valid, instr_out, instr_src, overrun}
  typedef struct {
    logic [1:0]  stb;
    logic [15:0] i0;
    logic [15:0] i1;
    logic        halt;
    logic        er;
    logic        clr;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   errors;

  task automatic drive(input logic [1:0] stb, input logic [15:0] i0, input logic [15:0] i1,
                       input logic h, input logic er, input logic clr);
    bus.src_strobe  = stb;
    bus.src_instr   = {i1, i0};
    bus.halt        = h;
    bus.exec_ready  = er;
    bus.overrun_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = {bus.instr_valid, bus.instr_out, bus.instr_src, bus.overrun};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%b out=%h src=%b ovr=%b, expected valid=%b out=%h src=%b ovr=%b",
               name, act[19], act[18:3], act[2], act[1:0], exp[19], exp[18:3], exp[2], exp[1:0]);
    end
  endtask

  task automatic do_reset();
    drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] hold_m [2];
    int          exp_ch;
    logic [1:0]  stb;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    //                stb    i0        i1        h     er    clr   {v, out, src, ovr}
    vq.push_back('{2'b10, 16'h0000, 16'hA5A5, 1'b0, 1'b1, 1'b0, {1'b0, 16'h0000, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'hA5A5, 1'b1, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b0, 16'hA5A5, 1'b1, 2'b00}});
    vq.push_back('{2'b11, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0, {1'b0, 16'hA5A5, 1'b1, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h1111, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h2222, 1'b1, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b0, 16'h2222, 1'b1, 2'b00}});
    vq.push_back('{2'b10, 16'h0000, 16'h0003, 1'b1, 1'b1, 1'b0, {1'b0, 16'h2222, 1'b1, 2'b00}});
    vq.push_back('{2'b10, 16'h0000, 16'h0007, 1'b1, 1'b1, 1'b0, {1'b0, 16'h2222, 1'b1, 2'b10}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h0003, 1'b1, 2'b10}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, {1'b0, 16'h0003, 1'b1, 2'b00}});
    vq.push_back('{2'b01, 16'h0055, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b0, 16'h0003, 1'b1, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b1, 16'h0055, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, {1'b1, 16'h0055, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b1, 16'h0055, 1'b0, 2'b00}});
    vq.push_back('{2'b01, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b1, 16'h0055, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, {1'b1, 16'h0055, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'hBEEF, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b0, 16'hBEEF, 1'b0, 2'b00}});
    vq.push_back('{2'b01, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, {1'b0, 16'hBEEF, 1'b0, 2'b00}});
    vq.push_back('{2'b01, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b0, 16'hBEEF, 1'b0, 2'b01}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h0001, 1'b0, 2'b01}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, {1'b0, 16'h0001, 1'b0, 2'b00}});
    vq.push_back('{2'b01, 16'h0A0A, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b0, 16'h0001, 1'b0, 2'b00}});
    vq.push_back('{2'b01, 16'h0B0B, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h0A0A, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b1, 16'h0B0B, 1'b0, 2'b00}});
    vq.push_back('{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, {1'b0, 16'h0B0B, 1'b0, 2'b00}});

    step();
    step();
    chk("reset_state", 20'h0);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].stb, vq[i].i0, vq[i].i1, vq[i].halt, vq[i].er, vq[i].clr);
      step();
      chk($sformatf("vec%0d", i), vq[i].exp);
    end

    // Arbitration order with the granted channel re-strobed every cycle.
    do_reset();
    hold_m[0] = 16'h0F00;
    hold_m[1] = 16'h0F01;
    drive(2'b11, hold_m[0], hold_m[1], 1'b0, 1'b1, 1'b0);
    step();
    chk("arb_load", 20'h0);
    for (int k = 0; k < 6; k++) begin
`ifdef INSTR_SEL_RR_EN
      exp_ch = k % 2;
`else
      exp_ch = 0;
`endif
      stb = (exp_ch == 0) ? 2'b01 : 2'b10;
      drive(stb, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("arb_grant%0d", k), {1'b1, hold_m[exp_ch], exp_ch[0], 2'b00});
      if (exp_ch == 0) hold_m[0] = 16'h1000 + 16'(k);
      else             hold_m[1] = 16'h2000 + 16'(k);
    end

    // Both channels pending and output valid: reset must discard everything.
    drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk("mid_reset", 20'h0);
    reset = 1'b0;
    bus.exec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_reset%0d", k), 20'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
